// File: rtl/data_ram_slave.sv
// Single-port word RAM behind a simple AXI-lite style slave.
// One transaction at a time; the write and read address share one bus.
module data_ram_slave #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_ARWADDR,
    input  logic        S_AWVALID,
    output logic        S_AWREADY,
    input  logic [31:0] S_WDATA,
    input  logic        S_WVALID,
    output logic        S_WREADY,
    output logic        S_BVALID,
    input  logic        S_BREADY,
    input  logic        S_ARVALID,
    output logic        S_ARREADY,
    output logic [31:0] S_RDATA,
    output logic        S_RVALID,
    input  logic        S_RREADY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RWAIT, RDATA} state_t;

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  ok_q, ok_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  mem_we;
    logic [31:0]           rd_word_arw, rd_word_lat;
    logic [31:0]           mem [DEPTH];
    logic                  unused_addr_bits;

    function automatic logic in_range(input logic [31:0] a);
        return (a >> (ADDR_WIDTH + 2)) == 32'd0;
    endfunction

    // Byte lanes are not supported, so the low address bits carry no meaning.
    assign unused_addr_bits = ^S_ARWADDR[1:0];

    assign rd_word_arw = in_range(S_ARWADDR) ? mem[S_ARWADDR[ADDR_WIDTH+1:2]] : 32'd0;
    assign rd_word_lat = ok_q ? mem[idx_q] : 32'd0;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ok_d      = ok_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_AWVALID)      state_d = WRITE;
                else if (S_ARVALID) state_d = RADDR;
            end
            WRITE: begin
                if (S_AWVALID && !aw_done_q) begin
                    aw_done_d = 1'b1;
                    idx_d     = S_ARWADDR[ADDR_WIDTH+1:2];
                    ok_d      = in_range(S_ARWADDR);
                end
                if (S_WVALID && !w_done_q) begin
                    w_done_d = 1'b1;
                    wdata_d  = S_WDATA;
                end
                // Commit on the edge where the second half of the pair lands.
                if (aw_done_d && w_done_d) begin
                    mem_we    = ok_d;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (S_BREADY) state_d = IDLE;
            end
            RADDR: begin
                if (S_ARVALID) begin
                    idx_d = S_ARWADDR[ADDR_WIDTH+1:2];
                    ok_d  = in_range(S_ARWADDR);
                    cnt_d = 4'(READ_LATENCY);
                    if (READ_LATENCY == 0) begin
                        rdata_d = rd_word_arw;
                        state_d = RDATA;
                    end else begin
                        state_d = RWAIT;
                    end
                end
            end
            RWAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = rd_word_lat;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (S_RREADY) begin
                    rdata_d = 32'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ok_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ok_q      <= ok_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage is deliberately not reset; reset only blocks the write via state_q.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_d] <= wdata_d;
    end

    assign S_AWREADY = (state_q == WRITE) && !aw_done_q;
    assign S_WREADY  = (state_q == WRITE) && !w_done_q;
    assign S_BVALID  = (state_q == WRESP);
    assign S_ARREADY = (state_q == RADDR);
    assign S_RVALID  = (state_q == RDATA);
    assign S_RDATA   = rdata_q;

endmodule

// File: doc/data_ram_slave.md
DATA_RAM_SLAVE -- requirements
Module: data_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-index width; memory depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 2, legal 0..15, meaning wait cycles between read-address acceptance and S_RVALID assertion.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port S_ARWADDR, input, 32 bits: shared byte address for reads and writes.
REQ-006 SHALL have ports S_AWVALID (input, 1) and S_AWREADY (output, 1): write-address handshake.
REQ-007 SHALL have ports S_WDATA (input, 32), S_WVALID (input, 1) and S_WREADY (output, 1): write-data handshake.
REQ-008 SHALL have ports S_BVALID (output, 1) and S_BREADY (input, 1): write-response handshake.
REQ-009 SHALL have ports S_ARVALID (input, 1) and S_ARREADY (output, 1): read-address handshake.
REQ-010 SHALL have ports S_RDATA (output, 32), S_RVALID (output, 1) and S_RREADY (input, 1): read-data handshake.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RWAIT, RDATA; all READY/VALID outputs decode from registered state/flags only, with no combinational path from inputs.
REQ-012 IDLE: all outputs 0; next state WRITE if S_AWVALID, else RADDR if S_ARVALID, else IDLE. Write wins when both are asserted.
REQ-013 WRITE: S_AWREADY = !aw_done and S_WREADY = !w_done. AW handshake sets aw_done and latches S_ARWADDR; W handshake sets w_done and latches S_WDATA. AW and W may complete in either order or in the same cycle.
REQ-014 On the clock edge where aw_done and w_done both become true, the latched word SHALL be written, state SHALL go to WRESP, and the flags SHALL clear.
REQ-015 WRESP: S_BVALID = 1, held until S_BREADY; on the handshake go to IDLE.
REQ-016 RADDR: S_ARREADY = 1; on handshake latch S_ARWADDR and load the wait counter with READ_LATENCY. Next state is RWAIT, or RDATA directly if READ_LATENCY = 0.
REQ-017 RWAIT: decrement the counter each cycle; go to RDATA when the counter reaches 1.
REQ-018 RDATA: S_RVALID = 1 and S_RDATA is a registered memory word; both SHALL be held stable until S_RREADY, then go to IDLE with S_RDATA cleared to 0.
REQ-019 Word index SHALL be S_ARWADDR[ADDR_WIDTH+1:2]; address bits [1:0] are ignored, and full-word writes only.
REQ-020 Out-of-range address (any bit [31:ADDR_WIDTH+2] set): the write is dropped and a read returns 32'h0. The handshake sequence SHALL be unchanged.
REQ-021 Read-after-write to the same word SHALL return the new data; no write is in flight when a read is accepted.
REQ-022 Minimum latency, counted in cycles from VALID assertion in IDLE: write 2 cycles to S_BVALID; read READ_LATENCY+2 cycles to S_RVALID.
REQ-023 Only one transaction SHALL be outstanding; S_ARVALID asserted during a write is serviced after return to IDLE.

Reset
REQ-024 While rst_n = 0, regardless of clk: state = IDLE, aw_done = w_done = 0, counter = 0, all READY/VALID outputs = 0, and S_RDATA = 0.
REQ-025 Reset mid-transaction SHALL abandon the transaction without a response; a write SHALL not reach memory unless its write edge preceded reset assertion.
REQ-026 Memory contents SHALL not be reset; they are undefined until written.

Verification
REQ-027 Write 0x0000_0010 with data 0xDEADBEEF (AW and W in the same cycle), then read 0x0000_0010 -> S_BVALID 2 cycles after VALID; S_RDATA = 0xDEADBEEF with S_RVALID 4 cycles after S_ARVALID.
REQ-028 S_AWVALID asserted 3 cycles before S_WVALID at address 0x24 with data 0x12345678 -> S_AWREADY drops after the AW handshake, no memory write until W completes, single S_BVALID; reading 0x27 returns 0x12345678.
REQ-029 S_AWVALID and S_ARVALID asserted together in IDLE -> write completes first (S_BVALID), then S_ARREADY; the read returns the just-written data.
REQ-030 Hold S_BREADY/S_RREADY low for 5 cycles -> S_BVALID/S_RVALID and S_RDATA stay stable for all 5 cycles, with no new READY asserted.
REQ-031 Write then read 0x0000_1000 with ADDR_WIDTH = 10 -> normal handshakes, read data 0, and word 0 unchanged.
REQ-032 Assert rst_n = 0 in RWAIT and in WRITE with only aw_done set -> all outputs 0 immediately; after release, S_BVALID/S_RVALID stay 0 with no spurious response, and memory is unchanged.
